// File: rtl/contador_pkg.sv
// Shared BCD digit type, limits and single-digit step arithmetic for the
// contador_bcd counter.
package contador_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Result of stepping one digit: wrap flags the carry/borrow into the next digit.
    typedef struct packed {
        logic wrap;
        bcd_t d;
    } bcd_step_t;

    function automatic logic bcd_valid(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

    function automatic bcd_step_t bcd_next(input bcd_t d, input logic up);
        bcd_step_t r;
        if (up) begin
            if (d >= BCD_MAX) r = '{wrap: 1'b1, d: BCD_MIN};
            else              r = '{wrap: 1'b0, d: d + 4'd1};
        end else begin
            if (d == BCD_MIN) r = '{wrap: 1'b1, d: BCD_MAX};
            else              r = '{wrap: 1'b0, d: d - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register of the counter chain; step_out ripples the
// carry/borrow into the next more significant digit.
module bcd_digit
    import contador_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  bcd_t load_d,
    input  logic step_in,
    input  logic up,
    output bcd_t d,
    output logic step_out
);

    bcd_step_t nxt;

    always_comb nxt = bcd_next(d, up);

    assign step_out = step_in & nxt.wrap;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            d <= BCD_MIN;
        end else if (load) begin
            d <= bcd_valid(load_d) ? load_d : BCD_MIN;
        end else if (step_in) begin
            d <= nxt.d;
        end
    end

endmodule

// File: rtl/contador_bcd.sv
// Multi-digit BCD up/down counter stepped by a prescaler tick or a pushbutton.
// Define CONTADOR_DEBOUNCE_EN to add a DEB_CYCLES stability filter on the button.
module contador_bcd
    import contador_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int PRESCALE   = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    step_btn,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    tick,
    output logic                    carry
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || PRESCALE < 2 || DEB_CYCLES < 1) begin : g_bad_params
        $error("contador_bcd: parameter out of range");
    end

    localparam int              PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (!en || load) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
            tick   <= 1'b1;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
            tick   <= 1'b0;
        end
    end

    // Two-flop synchronizer: sync[1] is the first metastability-safe copy.
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], step_btn};
    end

    logic btn_level;

`ifdef CONTADOR_DEBOUNCE_EN
    localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt;

    // Accept a new level only after it has differed from the current one for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (sync[1] == btn_level) begin
            deb_cnt   <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_level <= sync[1];
            deb_cnt   <= '0;
        end else begin
            deb_cnt   <= deb_cnt + 1'b1;
        end
    end
`else
    assign btn_level = sync[1];
`endif

    logic btn_prev;
    logic btn_step;

    always_ff @(posedge clk) begin
        if (rst) btn_prev <= 1'b0;
        else     btn_prev <= btn_level;
    end

    assign btn_step = btn_level & ~btn_prev;

    // chain[i] steps digit i; chain[NUM_DIGITS] means every digit wrapped.
    logic [NUM_DIGITS:0] chain;

    // NOTE: a combinational signal assigned on every path infers no latch.
    always_comb begin
        chain[0] = tick | btn_step;
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .load_d   (load_val[4*i +: 4]),
            .step_in  (chain[i]),
            .up       (up),
            .d        (bcd_out[4*i +: 4]),
            .step_out (chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || load) carry <= 1'b0;
        else             carry <= chain[NUM_DIGITS];
    end

endmodule

// File: tb/tb_contador_bcd.sv
// Directed self-checking bench for contador_bcd (NUM_DIGITS=2, PRESCALE=4, DEB_CYCLES=8);
// button timing expectations follow CONTADOR_DEBOUNCE_EN when it is defined.
module tb_contador_bcd;

    localparam int NUM_DIGITS = 2;
    localparam int PRESCALE   = 4;
    localparam int DEB_CYCLES = 8;

`ifdef CONTADOR_DEBOUNCE_EN
    localparam int  BTN_LAT = DEB_CYCLES + 2;
    localparam bit  DEB_ON  = 1'b1;
`else
    localparam int  BTN_LAT = 2;
    localparam bit  DEB_ON  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic       step_btn;
    logic [7:0] bcd_out;
    logic       tick;
    logic       carry;

    int n_checks = 0;
    int n_fail   = 0;

    contador_bcd #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .step_btn (step_btn),
        .bcd_out  (bcd_out),
        .tick     (tick),
        .carry    (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] load_val;
        logic       up;
        logic [7:0] exp_load;
        logic [7:0] exp_step;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [9];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] cur;
        logic       tick_seen;

        vecs[0] = '{8'h3C, 1'b1, 8'h30, 8'h31, 1'b0};
        vecs[1] = '{8'h99, 1'b1, 8'h99, 8'h00, 1'b1};
        vecs[2] = '{8'h99, 1'b0, 8'h99, 8'h98, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 8'h99, 1'b1};
        vecs[4] = '{8'h09, 1'b1, 8'h09, 8'h10, 1'b0};
        vecs[5] = '{8'h10, 1'b0, 8'h10, 8'h09, 1'b0};
        vecs[6] = '{8'hA5, 1'b1, 8'h05, 8'h06, 1'b0};
        vecs[7] = '{8'h5F, 1'b0, 8'h50, 8'h49, 1'b0};
        vecs[8] = '{8'hFF, 1'b1, 8'h00, 8'h01, 1'b0};

        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; step_btn = 1'b0;

        // Reset, then free-run counting 00..10 with a tick every 4th cycle.
        cyc(); cyc();
        check("rst_bcd", bcd_out, 0);
        check("rst_tick", tick, 0);
        check("rst_carry", carry, 0);
        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (3) cyc();
        for (int i = 1; i <= 10; i++) begin
            cyc();
            check("run_tick", tick, 1);
            cyc();
            check("run_bcd", bcd_out, 8'((i / 10) * 16 + (i % 10)));
            check("run_carry", carry, 0);
            repeat (2) cyc();
        end
        en = 1'b0;
        cyc();

        // Full wrap up then down, carry lasting exactly one cycle.
        load = 1'b1; load_val = 8'h99;
        cyc();
        load = 1'b0;
        check("wrap_load", bcd_out, 8'h99);
        en = 1'b1; up = 1'b1;
        repeat (3) cyc();
        cyc();
        check("wrap_up_tick", tick, 1);
        cyc();
        check("wrap_up_bcd", bcd_out, 8'h00);
        check("wrap_up_carry", carry, 1);
        cyc();
        check("wrap_up_carry_end", carry, 0);
        up = 1'b0;
        cyc();
        cyc();
        check("wrap_dn_tick", tick, 1);
        cyc();
        check("wrap_dn_bcd", bcd_out, 8'h99);
        check("wrap_dn_carry", carry, 1);
        cyc();
        check("wrap_dn_carry_end", carry, 0);
        en = 1'b0;
        cyc();

        // Table: load a value, then apply exactly one tick in the given direction.
        for (int v = 0; v < 9; v++) begin
            load = 1'b1; load_val = vecs[v].load_val; en = 1'b0;
            cyc();
            load = 1'b0;
            check("vec_load", bcd_out, vecs[v].exp_load);
            check("vec_load_carry", carry, 0);
            en = 1'b1; up = vecs[v].up;
            repeat (3) cyc();
            cyc();
            check("vec_tick", tick, 1);
            cyc();
            check("vec_step", bcd_out, vecs[v].exp_step);
            check("vec_carry", carry, vecs[v].exp_carry);
            en = 1'b0;
        end
        cyc();

        // Load in the same cycle as a tick: load wins and the prescaler restarts.
        load = 1'b1; load_val = 8'h05;
        cyc();
        load = 1'b0; en = 1'b1; up = 1'b1;
        repeat (3) cyc();
        cyc();
        check("ldtick_tick", tick, 1);
        load = 1'b1; load_val = 8'h3C;
        cyc();
        load = 1'b0;
        check("ldtick_bcd", bcd_out, 8'h30);
        check("ldtick_carry", carry, 0);
        check("ldtick_no_tick", tick, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("ldtick_restart", tick, 0);
        end
        cyc();
        check("ldtick_next_tick", tick, 1);
        cyc();
        check("ldtick_step", bcd_out, 8'h31);
        en = 1'b0;
        cyc();

        // Button held for 20 cycles with en=0: exactly one step, no ticks.
        step_btn = 1'b1;
        tick_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            tick_seen = tick_seen | tick;
        end
        check("hold_bcd", bcd_out, 8'h32);
        check("hold_no_tick", tick_seen, 0);
        step_btn = 1'b0;
        repeat (14) cyc();
        check("hold_release", bcd_out, 8'h32);

        // Accepted button edge lands in the same cycle as the third tick.
        en = 1'b1; up = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            cyc();
            if (e == 12 - BTN_LAT) step_btn = 1'b1;
            if (e == 12) check("coinc_tick", tick, 1);
        end
        check("coinc_bcd", bcd_out, 8'h35);
        step_btn = 1'b0; en = 1'b0;
        repeat (14) cyc();
        check("coinc_release", bcd_out, 8'h35);

        // Short 3-cycle pulse: filtered with debounce, one step without.
        step_btn = 1'b1;
        repeat (3) cyc();
        step_btn = 1'b0;
        repeat (14) cyc();
        cur = DEB_ON ? 8'h35 : 8'h36;
        check("pulse_bcd", bcd_out, cur);

        // Steady 10-cycle press: step lands exactly BTN_LAT+1 edges after the press.
        step_btn = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            cyc();
            if (i == 10) step_btn = 1'b0;
            if (i == BTN_LAT)     check("press_before", bcd_out, cur);
            if (i == BTN_LAT + 1) check("press_step", bcd_out, cur + 8'h01);
        end
        step_btn = 1'b0;
        repeat (14) cyc();
        check("press_single", bcd_out, cur + 8'h01);

        // Reset mid-count with the prescaler at terminal count and a button press in flight.
        load = 1'b1; load_val = 8'h47;
        cyc();
        load = 1'b0;
        check("mid_load", bcd_out, 8'h47);
        en = 1'b1; up = 1'b1;
        cyc(); cyc();
        step_btn = 1'b1;
        cyc();
        rst = 1'b1; step_btn = 1'b0;
        cyc();
        check("mid_rst_bcd", bcd_out, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_carry", carry, 0);
        rst = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            cyc();
            check("post_rst_tick", tick, (r == 4) ? 1 : 0);
            check("post_rst_bcd", bcd_out, 0);
        end
        cyc();
        check("post_rst_step", bcd_out, 8'h01);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
